// File: rtl/word_entry_pkg.sv
// Shared state encoding and ASCII constants for the word entry block.
package word_entry_pkg;

    typedef enum logic [1:0] {
        ENTER_WORD = 2'd0,
        CONFIRM    = 2'd1,
        PLAY       = 2'd2,
        DONE       = 2'd3
    } entry_state_t;

    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_Z  = 8'h5A;
    localparam logic [7:0] ASCII_LA = 8'h61;
    localparam logic [7:0] ASCII_LZ = 8'h7A;
    localparam logic [7:0] CASE_OFS = 8'h20;

endpackage

// File: rtl/word_entry_if.sv
// Keypad / game-logic signal bundle between the host side and word_entry.
interface word_entry_if #(
    parameter int WORD_LEN = 5,
    parameter int CHAR_W   = 8
);
    logic [CHAR_W-1:0]          key_ascii;
    logic                       key_valid;
    logic                       key_del;
    logic                       key_enter;
    logic                       game_rdy;
    logic                       gameEnd;
    logic [WORD_LEN*CHAR_W-1:0] setWord;
    logic                       toggle_state;
    logic [CHAR_W-1:0]          guess;
    logic                       guess_valid;
    logic [2:0]                 entry_count;
    logic [25:0]                guessed_mask;
    logic                       dup_guess;
    logic                       drop_key;
    logic                       pending;

    modport slave (
        input  key_ascii, key_valid, key_del, key_enter, game_rdy, gameEnd,
        output setWord, toggle_state, guess, guess_valid, entry_count,
               guessed_mask, dup_guess, drop_key, pending
    );

    modport master (
        output key_ascii, key_valid, key_del, key_enter, game_rdy, gameEnd,
        input  setWord, toggle_state, guess, guess_valid, entry_count,
               guessed_mask, dup_guess, drop_key, pending
    );
endinterface

// File: rtl/word_entry_ascii_filter.sv
// Classifies a keypad byte as a letter, folds lower case to upper case and
// gives its 0..25 alphabet index.
module ascii_filter
    import word_entry_pkg::*;
#(
    parameter int CHAR_W = 8
) (
    input  logic [CHAR_W-1:0] i_key_ascii,
    output logic              o_is_letter,
    output logic [CHAR_W-1:0] o_letter,
    output logic [4:0]        o_idx
);
    logic w_upper;
    logic w_lower;

    assign w_upper     = (i_key_ascii >= CHAR_W'(ASCII_A))  && (i_key_ascii <= CHAR_W'(ASCII_Z));
    assign w_lower     = (i_key_ascii >= CHAR_W'(ASCII_LA)) && (i_key_ascii <= CHAR_W'(ASCII_LZ));
    assign o_is_letter = w_upper | w_lower;
    assign o_letter    = w_lower ? i_key_ascii - CHAR_W'(CASE_OFS) : i_key_ascii;
    assign o_idx       = 5'(o_letter - CHAR_W'(ASCII_A));
endmodule

// File: rtl/word_entry.sv
// Builds the secret word from keypad strobes, confirms it, then turns player
// keystrokes into single-buffered, de-duplicated guesses for the game logic.
module word_entry
    import word_entry_pkg::*;
#(
    parameter int WORD_LEN = 5,
    parameter int CHAR_W   = 8
) (
    input  logic         clk,
    input  logic         nRst,
    word_entry_if.slave  bus
);
    localparam int         WW   = WORD_LEN * CHAR_W;
    localparam logic [2:0] FULL = 3'(WORD_LEN);

    entry_state_t      r_state, w_next;
    logic [WW-1:0]     r_word;
    logic [2:0]        r_count;
    logic [25:0]       r_mask;
    logic [CHAR_W-1:0] r_guess, r_buf;
    logic [4:0]        r_buf_idx;
    logic              r_buf_vld, r_gv, r_dup, r_drop;

    logic              w_is_letter;
    logic [CHAR_W-1:0] w_letter;
    logic [4:0]        w_idx;
    logic              w_del, w_enter, w_key, w_take, w_bad, w_issue, w_repeat;

    ascii_filter #(.CHAR_W(CHAR_W)) u_filter (
        .i_key_ascii (bus.key_ascii),
        .o_is_letter (w_is_letter),
        .o_letter    (w_letter),
        .o_idx       (w_idx)
    );

    // Strobe priority: delete, then enter, then character.
    assign w_del    = bus.key_del;
    assign w_enter  = bus.key_enter & ~bus.key_del;
    assign w_key    = bus.key_valid & ~bus.key_del & ~bus.key_enter;
    assign w_take   = w_key & w_is_letter;
    assign w_bad    = w_key & ~w_is_letter;
    assign w_issue  = r_buf_vld & bus.game_rdy & ~bus.gameEnd;
    assign w_repeat = r_mask[w_idx] | (r_buf_vld & (r_buf == w_letter));

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) r_state <= ENTER_WORD;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ENTER_WORD: if (w_enter && r_count == FULL) w_next = CONFIRM;
            CONFIRM:    w_next = PLAY;
            PLAY:       if (bus.gameEnd) w_next = DONE;
            DONE:       if (w_enter) w_next = ENTER_WORD;
            default:    w_next = ENTER_WORD;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_word    <= '0;
            r_count   <= '0;
            r_mask    <= '0;
            r_guess   <= '0;
            r_buf     <= '0;
            r_buf_idx <= '0;
            r_buf_vld <= 1'b0;
            r_gv      <= 1'b0;
            r_dup     <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_gv   <= 1'b0;
            r_dup  <= 1'b0;
            r_drop <= w_bad;
            case (r_state)
                ENTER_WORD: begin
                    if (w_del) begin
                        if (r_count != 3'd0) begin
                            r_word  <= {{CHAR_W{1'b0}}, r_word[WW-1:CHAR_W]};
                            r_count <= r_count - 3'd1;
                        end
                    end else if (w_take && r_count != FULL) begin
                        r_word  <= {r_word[WW-CHAR_W-1:0], w_letter};
                        r_count <= r_count + 3'd1;
                    end
                end
                PLAY: begin
                    if (bus.gameEnd) begin
                        r_buf_vld <= 1'b0;
                    end else begin
                        if (w_issue) begin
                            r_guess           <= r_buf;
                            r_gv              <= 1'b1;
                            r_mask[r_buf_idx] <= 1'b1;
                            r_buf_vld         <= 1'b0;
                        end
                        // An issuing buffer frees its slot for a letter arriving this cycle.
                        if (w_take) begin
                            if (w_repeat) begin
                                r_dup <= 1'b1;
                            end else if (!r_buf_vld || w_issue) begin
                                r_buf     <= w_letter;
                                r_buf_idx <= w_idx;
                                r_buf_vld <= 1'b1;
                            end else begin
                                r_drop <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    if (w_enter) begin
                        r_word  <= '0;
                        r_count <= '0;
                        r_mask  <= '0;
                        r_guess <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.setWord      = r_word;
    assign bus.toggle_state = (r_state == CONFIRM);
    assign bus.guess        = r_guess;
    assign bus.guess_valid  = r_gv;
    assign bus.entry_count  = r_count;
    assign bus.guessed_mask = r_mask;
    assign bus.dup_guess    = r_dup;
    assign bus.drop_key     = r_drop;
    assign bus.pending      = r_buf_vld;
endmodule

// File: tb/tb_word_entry.sv
// Bench for word_entry: table-driven word entry, directed play/restart/reset
// sequences, and randomized play checked against a queue-based guess model.
module tb_word_entry;
    localparam int WL = 5;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic nRst = 1'b0;
    always #5 clk = ~clk;

    word_entry_if #(.WORD_LEN(WL), .CHAR_W(CW)) bus();
    word_entry #(.WORD_LEN(WL), .CHAR_W(CW)) dut (.clk(clk), .nRst(nRst), .bus(bus));

    int errors = 0;
    int checks = 0;

    logic [25:0] m_mask;
    logic [7:0]  m_q[$];
    logic [7:0]  m_guess;

    typedef struct {
        logic [7:0]  c;
        bit          kv, del, ent;
        logic [2:0]  cnt;
        logic [39:0] word;
        bit          drop;
    } vec_t;
    vec_t tbl[19];

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h @%0t", n, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit kv, input logic [7:0] c, input bit del, input bit ent);
        bus.key_valid = kv; bus.key_ascii = c; bus.key_del = del; bus.key_enter = ent;
        tick();
        bus.key_valid = 0; bus.key_del = 0; bus.key_enter = 0;
    endtask

    task automatic key(input logic [7:0] c);
        drive(1, c, 0, 0);
    endtask

    // Reference: one pending slot as a queue, guessed letters as a bit set.
    task automatic step(input bit kv, input logic [7:0] c, input bit rdy);
        bit is_l, dup, drp, gv;
        logic [7:0] L;
        is_l = (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A);
        L    = (c >= 8'h61) ? c - 8'h20 : c;
        dup = 0; drp = 0; gv = 0;
        if (kv && !is_l) drp = 1;
        else if (kv) dup = m_mask[int'(L) - 65] || (m_q.size() != 0 && m_q[0] == L);
        if (rdy && m_q.size() != 0) begin
            m_guess = m_q.pop_front();
            m_mask[int'(m_guess) - 65] = 1'b1;
            gv = 1;
        end
        if (kv && is_l && !dup) begin
            if (m_q.size() == 0) m_q.push_back(L);
            else drp = 1;
        end
        bus.game_rdy = rdy;
        drive(kv, c, 0, 0);
        chk("rnd_guess_valid", bus.guess_valid, gv);
        chk("rnd_guess", bus.guess, m_guess);
        chk("rnd_dup", bus.dup_guess, dup);
        chk("rnd_drop", bus.drop_key, drp);
        chk("rnd_pending", bus.pending, m_q.size() != 0);
        chk("rnd_mask", bus.guessed_mask, m_mask);
    endtask

    initial begin
        bus.key_ascii = 0; bus.key_valid = 0; bus.key_del = 0; bus.key_enter = 0;
        bus.game_rdy = 0; bus.gameEnd = 0;

        tbl[0]  = '{8'h00, 0, 1, 0, 3'd0, 40'h0, 0};
        tbl[1]  = '{8'h61, 1, 0, 0, 3'd1, 40'h41, 0};
        tbl[2]  = '{8'h31, 1, 0, 0, 3'd1, 40'h41, 1};
        tbl[3]  = '{8'h50, 1, 0, 0, 3'd2, 40'h4150, 0};
        tbl[4]  = '{8'h40, 1, 0, 0, 3'd2, 40'h4150, 1};
        tbl[5]  = '{8'h5B, 1, 0, 0, 3'd2, 40'h4150, 1};
        tbl[6]  = '{8'h60, 1, 0, 0, 3'd2, 40'h4150, 1};
        tbl[7]  = '{8'h7B, 1, 0, 0, 3'd2, 40'h4150, 1};
        tbl[8]  = '{8'h7A, 1, 0, 0, 3'd3, 40'h41505A, 0};
        tbl[9]  = '{8'h00, 0, 1, 0, 3'd2, 40'h4150, 0};
        tbl[10] = '{8'h51, 1, 1, 0, 3'd1, 40'h41, 0};
        tbl[11] = '{8'h58, 1, 0, 1, 3'd1, 40'h41, 0};
        tbl[12] = '{8'h70, 1, 0, 0, 3'd2, 40'h4150, 0};
        tbl[13] = '{8'h50, 1, 0, 0, 3'd3, 40'h415050, 0};
        tbl[14] = '{8'h4C, 1, 0, 0, 3'd4, 40'h4150504C, 0};
        tbl[15] = '{8'h65, 1, 0, 0, 3'd5, 40'h4150504C45, 0};
        tbl[16] = '{8'h5A, 1, 0, 0, 3'd5, 40'h4150504C45, 0};
        tbl[17] = '{8'h00, 0, 1, 0, 3'd4, 40'h004150504C, 0};
        tbl[18] = '{8'h45, 1, 0, 0, 3'd5, 40'h4150504C45, 0};

        repeat (2) tick();
        chk("rst_setWord", bus.setWord, 0);
        chk("rst_count", bus.entry_count, 0);
        chk("rst_toggle", bus.toggle_state, 0);
        chk("rst_gv", bus.guess_valid, 0);
        chk("rst_pending", bus.pending, 0);
        chk("rst_mask", bus.guessed_mask, 0);
        nRst = 1;
        tick();

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].kv, tbl[i].c, tbl[i].del, tbl[i].ent);
            chk($sformatf("tbl%0d_count", i), bus.entry_count, tbl[i].cnt);
            chk($sformatf("tbl%0d_word", i), bus.setWord, tbl[i].word);
            chk($sformatf("tbl%0d_drop", i), bus.drop_key, tbl[i].drop);
            chk($sformatf("tbl%0d_toggle", i), bus.toggle_state, 0);
        end

        drive(0, 0, 0, 1);
        chk("confirm_toggle", bus.toggle_state, 1);
        tick();
        chk("confirm_toggle_off", bus.toggle_state, 0);

        // Guess latency and duplicate rejection.
        bus.game_rdy = 1;
        key(8'h63);
        chk("c_pending", bus.pending, 1);
        chk("c_gv_early", bus.guess_valid, 0);
        tick();
        chk("c_gv", bus.guess_valid, 1);
        chk("c_guess", bus.guess, 8'h43);
        chk("c_mask", bus.guessed_mask, 26'h4);
        tick();
        chk("c_gv_pulse", bus.guess_valid, 0);
        chk("c_guess_held", bus.guess, 8'h43);
        key(8'h43);
        chk("C_dup", bus.dup_guess, 1);
        tick();
        chk("C_no_gv", bus.guess_valid, 0);
        chk("C_no_pending", bus.pending, 0);

        // Buffer full while game not ready.
        bus.game_rdy = 0;
        key(8'h4A);
        chk("J_pending", bus.pending, 1);
        key(8'h51);
        chk("Q_drop", bus.drop_key, 1);
        key(8'h6A);
        chk("j_dup_buf", bus.dup_guess, 1);
        bus.game_rdy = 1;
        tick();
        chk("J_gv", bus.guess_valid, 1);
        chk("J_guess", bus.guess, 8'h4A);
        chk("J_pending_off", bus.pending, 0);
        chk("J_mask", bus.guessed_mask, 26'h204);
        tick();
        chk("J_gv_once", bus.guess_valid, 0);

        m_mask = 26'h204;
        m_guess = 8'h4A;
        for (int i = 0; i < 200; i++) begin
            logic [7:0] c;
            if ($urandom_range(0, 9) == 0) c = 8'($urandom_range(0, 64));
            else c = 8'(8'h41 + $urandom_range(0, 12) + ($urandom_range(0, 1) != 0 ? 32 : 0));
            step($urandom_range(0, 3) != 0, c, $urandom_range(0, 2) != 0);
        end
        step(0, 0, 1);
        step(0, 0, 1);
        chk("play_word_frozen", bus.setWord, 40'h4150504C45);
        step(1, 8'h57, 0);

        // gameEnd wins over a same-cycle issue.
        bus.game_rdy = 1; bus.gameEnd = 1;
        tick();
        bus.gameEnd = 0;
        chk("end_pending", bus.pending, 0);
        chk("end_no_gv", bus.guess_valid, 0);
        chk("end_mask", bus.guessed_mask, m_mask);
        tick();
        chk("end_no_gv2", bus.guess_valid, 0);
        key(8'h42);
        chk("done_no_dup", bus.dup_guess, 0);
        chk("done_no_drop", bus.drop_key, 0);
        chk("done_count", bus.entry_count, 5);
        drive(0, 0, 0, 1);
        chk("restart_word", bus.setWord, 0);
        chk("restart_count", bus.entry_count, 0);
        chk("restart_mask", bus.guessed_mask, 0);
        chk("restart_guess", bus.guess, 0);

        key(8'h4D); key(8'h4F); key(8'h58);
        drive(0, 0, 1, 0);
        chk("mox_word", bus.setWord, 40'h4D4F);
        chk("mox_count", bus.entry_count, 2);
        drive(0, 0, 0, 1);
        chk("short_enter_toggle", bus.toggle_state, 0);
        key(8'h4F); key(8'h52); key(8'h45);
        chk("more_word", bus.setWord, 40'h4D4F4F5245);
        drive(0, 0, 0, 1);
        chk("more_toggle", bus.toggle_state, 1);

        // Asynchronous reset in the confirm cycle.
        nRst = 0;
        #1;
        chk("arst_toggle", bus.toggle_state, 0);
        chk("arst_word", bus.setWord, 0);
        chk("arst_count", bus.entry_count, 0);
        @(negedge clk);
        nRst = 1;
        key(8'h41);
        chk("post_rst_count", bus.entry_count, 1);
        chk("post_rst_word", bus.setWord, 40'h41);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/word_entry.md
Name: word_entry

Overview:
- Producer side of the game interface.
- Assembles the host's secret word from keypad ASCII strobes, then confirms it with a one-cycle toggle_state pulse.
- During play, turns player keystrokes into guesses for Game_logic, which are issued only when game_rdy is high.
- Buffers one pending guess and rejects letters already guessed.

Parameters:
- WORD_LEN, 5: letters per word.
- CHAR_W, 8: bits per character (ASCII).

Ports:
- clk  in  1  system clock
- nRst  in  1  asynchronous active-low reset
- key_ascii  in  CHAR_W  keypad character
- key_valid  in  1  one-cycle strobe: key_ascii valid
- key_del  in  1  one-cycle strobe: delete last word letter
- key_enter  in  1  one-cycle strobe: confirm word / restart game
- game_rdy  in  1  Game_logic can accept a guess
- gameEnd  in  1  Game_logic reports win or loss
- setWord  out  WORD_LEN*CHAR_W  secret word; first letter in MSBs
- toggle_state  out  1  one-cycle pulse: word confirmed
- guess  out  CHAR_W  current guess letter; held after issue
- guess_valid  out  1  one-cycle pulse: new guess placed on guess
- entry_count  out  3  letters entered so far (0..WORD_LEN)
- guessed_mask  out  26  bit i set = letter 'A'+i already issued
- dup_guess  out  1  pulse: letter rejected as repeat
- drop_key  out  1  pulse: letter lost because buffer full, or key invalid
- pending  out  1  a guess is buffered awaiting game_rdy

Behaviour:
- Reset: outputs 0, state ENTER_WORD, pending buffer empty.
- Key normalisation: 0x41-0x5A accepted as is; 0x61-0x7A folded by subtracting 0x20.
- Invalid key: any other key_valid pulses drop_key one cycle; no other effect.
- Simultaneous strobes: key_del > key_enter > key_valid; lower-priority strobes in the same cycle are discarded.
- States: ENTER_WORD, CONFIRM, PLAY, DONE.
- ENTER_WORD, letter accepted with count<WORD_LEN: setWord <= {setWord[low bits], letter}; count++.
  - count==WORD_LEN: further letters ignored.
- ENTER_WORD, key_del with count>0: setWord <= {CHAR_W'0, setWord[upper bits]}; count--.
  - key_del with count==0 is ignored.
- ENTER_WORD, key_enter: moves to CONFIRM only when count==WORD_LEN; ignored otherwise.
- CONFIRM: toggle_state=1 for exactly that cycle; setWord frozen from here until DONE exit; next state PLAY.
- PLAY, letter accepted:
  - letter's mask bit set, or letter equals the buffered letter: dup_guess pulse, nothing else.
  - buffer empty: letter is loaded into the buffer.
  - buffer full: drop_key pulse.
- PLAY, issue: in any cycle with buffer full and game_rdy=1:
  - guess <= buffer, guess_valid=1 the following cycle;
  - mask bit set, buffer emptied.
- Same-cycle issue and arrival: a letter arriving while the buffer issues is accepted into the emptied buffer.
- Latency: key_valid to guess_valid is 2 cycles when the buffer is empty and game_rdy=1.
- PLAY, gameEnd=1: move to DONE and clear the buffer; this takes priority over an issue in the same cycle.
- DONE: letters are ignored (no pulses).
  - key_enter clears setWord, entry_count, guessed_mask and guess, then returns to ENTER_WORD.
- Reset mid-operation returns to the reset state at once; a pulse already in flight is truncated.
- entry_count saturates at WORD_LEN and never wraps.

Decomposition:
- Package word_entry_pkg:
  - entry_state_t (ENTER_WORD=0, CONFIRM=1, PLAY=2, DONE=3);
  - ASCII_A=8'h41, ASCII_Z=8'h5A, ASCII_LA=8'h61, ASCII_LZ=8'h7A, CASE_OFS=8'h20.
- One sub-module: ascii_filter, combinational.
  - Inputs: key_ascii.
  - Outputs: is_letter, upper-case letter, 5-bit alphabet index.

Test Plan:
- Type a,P,P,L,E, then key_enter -> setWord=40'h4150504C45, entry_count=5, toggle_state high exactly 1 cycle, state PLAY.
- Type M,O,X, key_del, then key_enter -> setWord=40'h00004D4F, entry_count=2, enter ignored (no toggle_state); then O,R,E, enter -> setWord=40'h4D4F4F5245.
- In PLAY with game_rdy=1, type 'c' -> guess=8'h43 and guess_valid 2 cycles after the key, guessed_mask[2]=1; type 'C' again -> dup_guess pulse, no guess_valid.
- Hold game_rdy=0, type J then Q -> pending=1 holding J, drop_key pulse for Q; raise game_rdy -> guess=8'h4A issued once, pending=0.
- Assert gameEnd with J buffered and game_rdy=0 -> buffer cleared, no guess_valid; key_enter -> setWord=0, guessed_mask=0, state ENTER_WORD.
- Assert nRst low during the CONFIRM cycle -> toggle_state drops immediately, all outputs 0.
